// File: rtl/matrix_encoder_sched.sv
// matrix_encoder_sched
// Sequences NUM_STAGES stage engines for NUM_ROUNDS rounds over a pair of
// ping-pong line banks. Each stage is launched with a one-cycle one-hot pulse,
// its line writes are routed to the destination bank, and after it reports
// done the banks swap and the next stage (or round) is launched.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   start, abort        : run request (ignored while busy), synchronous cancel
//   busy, done, err     : run in progress, end-of-run pulse, sticky error
//   round, stage_sel    : current round / stage index
//   stage_start         : one-hot launch pulse to the selected stage
//   stage_done/cnt/we/wdata : per-stage status and write port (flat vectors)
//   rd_bank, rd_addr    : source bank select and line address
//   wr_en, wr_bank, wr_addr, wr_data : destination write port
//   result_bank         : bank holding the final state after done
module matrix_encoder_sched #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_ROUNDS = 24,
    parameter int TIMEOUT    = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [4:0]                round,
    output logic [2:0]                stage_sel,
    output logic [NUM_STAGES-1:0]     stage_start,
    input  logic [NUM_STAGES-1:0]     stage_done,
    input  logic [7*NUM_STAGES-1:0]   stage_cnt,
    input  logic [NUM_STAGES-1:0]     stage_we,
    input  logic [25*NUM_STAGES-1:0]  stage_wdata,
    output logic                      rd_bank,
    output logic [5:0]                rd_addr,
    output logic                      wr_en,
    output logic                      wr_bank,
    output logic [5:0]                wr_addr,
    output logic [24:0]               wr_data,
    output logic                      result_bank
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        SWAP   = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t                  state_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_r;
    logic [4:0]              round_r;
    logic [2:0]              stage_sel_r;
    logic [NUM_STAGES-1:0]   stage_start_r;
    logic                    rd_bank_r;
    logic                    result_bank_r;
    logic [6:0]              wr_cnt_r;
    logic [TW-1:0]           to_cnt_r;

    logic                    hit_s;
    logic                    sel_done_s;
    logic                    sel_we_s;
    logic [6:0]              sel_cnt_s;
    logic [24:0]             sel_wdata_s;
    logic                    in_wait_s;

    // One-hot launch vector for a stage index.
    function automatic logic [NUM_STAGES-1:0] onehot(input logic [2:0] idx);
        logic [NUM_STAGES-1:0] v;
        for (int k = 0; k < NUM_STAGES; k++) begin
            v[k] = (idx == 3'(k));
        end
        return v;
    endfunction

    // Select the active stage's status and write port; other stages are masked off.
    always_comb begin
        hit_s       = 1'b0;
        sel_done_s  = 1'b0;
        sel_we_s    = 1'b0;
        sel_cnt_s   = 7'd0;
        sel_wdata_s = 25'd0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            hit_s       = (stage_sel_r == 3'(k));
            sel_done_s  = sel_done_s | (stage_done[k] & hit_s);
            sel_we_s    = sel_we_s | (stage_we[k] & hit_s);
            sel_cnt_s   = sel_cnt_s | (stage_cnt[7*k +: 7] & {7{hit_s}});
            sel_wdata_s = sel_wdata_s | (stage_wdata[25*k +: 25] & {25{hit_s}});
        end
    end

    assign in_wait_s = (state_r == WAIT);

    // The stage reads the line after its current counter; the 7-bit sum wraps to 6 bits.
    assign rd_addr     = in_wait_s ? 6'(sel_cnt_s + 7'd1) : 6'd0;
    assign wr_en       = in_wait_s & sel_we_s;
    assign wr_data     = in_wait_s ? sel_wdata_s : 25'd0;
    assign wr_addr     = wr_cnt_r[5:0];
    assign wr_bank     = ~rd_bank_r;

    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign round       = round_r;
    assign stage_sel   = stage_sel_r;
    assign stage_start = stage_start_r;
    assign rd_bank     = rd_bank_r;
    assign result_bank = result_bank_r;

    // Scheduler FSM: launch, wait, swap banks, advance stage/round, finish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            round_r       <= 5'd0;
            stage_sel_r   <= 3'd0;
            stage_start_r <= {NUM_STAGES{1'b0}};
            rd_bank_r     <= 1'b0;
            result_bank_r <= 1'b0;
            wr_cnt_r      <= 7'd0;
            to_cnt_r      <= {TW{1'b0}};
        end else begin
            done_r        <= 1'b0;
            stage_start_r <= {NUM_STAGES{1'b0}};
            if ((state_r != IDLE) && abort) begin
                // Cancel wins over everything else, including stage_done.
                state_r <= IDLE;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            round_r       <= 5'd0;
                            stage_sel_r   <= 3'd0;
                            rd_bank_r     <= 1'b0;
                            err_r         <= 1'b0;
                            stage_start_r <= onehot(3'd0);
                            busy_r        <= 1'b1;
                            state_r       <= LAUNCH;
                        end else begin
                            busy_r        <= 1'b0;
                        end
                    end
                    LAUNCH: begin
                        wr_cnt_r <= 7'd0;
                        to_cnt_r <= {TW{1'b0}};
                        state_r  <= WAIT;
                    end
                    WAIT: begin
                        if (wr_en) begin
                            wr_cnt_r <= wr_cnt_r + 7'd1;
                        end else begin
                            wr_cnt_r <= wr_cnt_r;
                        end
                        if (sel_done_s) begin
                            state_r <= SWAP;
                        end else if (to_cnt_r == TW'(TIMEOUT - 1)) begin
                            // This cycle is the TIMEOUT-th one spent waiting.
                            err_r   <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            to_cnt_r <= to_cnt_r + TW'(1);
                        end
                    end
                    SWAP: begin
                        if (wr_cnt_r != 7'd64) begin
                            err_r <= 1'b1;
                        end else begin
                            err_r <= err_r;
                        end
                        rd_bank_r <= ~rd_bank_r;
                        if (stage_sel_r < 3'(NUM_STAGES - 1)) begin
                            stage_sel_r   <= stage_sel_r + 3'd1;
                            stage_start_r <= onehot(stage_sel_r + 3'd1);
                            state_r       <= LAUNCH;
                        end else if (round_r < 5'(NUM_ROUNDS - 1)) begin
                            stage_sel_r   <= 3'd0;
                            round_r       <= round_r + 5'd1;
                            stage_start_r <= onehot(3'd0);
                            state_r       <= LAUNCH;
                        end else begin
                            // done is high for the single FINISH cycle.
                            done_r        <= 1'b1;
                            result_bank_r <= ~rd_bank_r;
                            state_r       <= FINISH;
                        end
                    end
                    FINISH: begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_encoder_sched.sv
// Directed bench for matrix_encoder_sched: nominal two-stage/two-round run,
// short write, address mapping, timeout, abort/start interplay and
// asynchronous reset mid-run. A second instance with TIMEOUT=16 covers the
// timeout path.
module tb_matrix_encoder_sched;

    localparam int NS = 2;

    logic clk = 1'b0;
    logic rst;
    logic start, abort;
    logic [NS-1:0]     stage_done, stage_we;
    logic [7*NS-1:0]   stage_cnt;
    logic [25*NS-1:0]  stage_wdata;
    logic busy, done, err, rd_bank, wr_en, wr_bank, result_bank;
    logic [4:0]  round;
    logic [2:0]  stage_sel;
    logic [NS-1:0] stage_start;
    logic [5:0]  rd_addr, wr_addr;
    logic [24:0] wr_data;

    logic start_t;
    logic busy_t, done_t, err_t, rd_bank_t, wr_en_t, wr_bank_t, result_bank_t;
    logic [4:0]  round_t;
    logic [2:0]  stage_sel_t;
    logic [NS-1:0] stage_start_t;
    logic [5:0]  rd_addr_t, wr_addr_t;
    logic [24:0] wr_data_t;

    int nvec = 0;
    int nfail = 0;
    int done_seen = 0;
    int done_seen_t = 0;

    always #5 clk = ~clk;

    matrix_encoder_sched #(.NUM_STAGES(NS), .NUM_ROUNDS(2), .TIMEOUT(200)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err), .round(round), .stage_sel(stage_sel),
        .stage_start(stage_start), .stage_done(stage_done), .stage_cnt(stage_cnt),
        .stage_we(stage_we), .stage_wdata(stage_wdata), .rd_bank(rd_bank),
        .rd_addr(rd_addr), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data), .result_bank(result_bank)
    );

    matrix_encoder_sched #(.NUM_STAGES(NS), .NUM_ROUNDS(2), .TIMEOUT(16)) dut_to (
        .clk(clk), .rst(rst), .start(start_t), .abort(1'b0),
        .busy(busy_t), .done(done_t), .err(err_t), .round(round_t), .stage_sel(stage_sel_t),
        .stage_start(stage_start_t), .stage_done(2'b00), .stage_cnt(14'd0),
        .stage_we(2'b00), .stage_wdata(50'd0), .rd_bank(rd_bank_t),
        .rd_addr(rd_addr_t), .wr_en(wr_en_t), .wr_bank(wr_bank_t), .wr_addr(wr_addr_t),
        .wr_data(wr_data_t), .result_bank(result_bank_t)
    );

    // Count end-of-run pulses on both instances.
    always @(negedge clk) begin
        if (done === 1'b1) done_seen <= done_seen + 1;
        if (done_t === 1'b1) done_seen_t <= done_seen_t + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] pat(input int idx, input int i);
        return 25'h0A5000 ^ 25'(idx * 65536) ^ 25'(i);
    endfunction

    task automatic clear_stage_inputs();
        stage_done  = '0;
        stage_we    = '0;
        stage_cnt   = '0;
        stage_wdata = '0;
    endtask

    task automatic wait_launch(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (stage_start !== 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Launch check, then nwr writes from stage idx while the other stage
    // asserts junk; optionally finish the stage with a done pulse.
    task automatic run_stage(input int idx, input int nwr, input int exp_round,
                             input int exp_bank, input int exp_err, input bit finish_stage);
        bit ok;
        int oth;
        oth = 1 - idx;
        wait_launch(ok);
        check("launch_seen", 32'(ok), 32'd1);
        check("stage_start", 32'(stage_start), (idx == 0) ? 32'd1 : 32'd2);
        check("round", 32'(round), 32'(exp_round));
        check("stage_sel", 32'(stage_sel), 32'(idx));
        check("err_at_launch", 32'(err), 32'(exp_err));
        check("busy_run", 32'(busy), 32'd1);
        @(negedge clk);
        stage_done[oth] = 1'b1;
        stage_we[oth]   = 1'b1;
        stage_cnt[oth*7 +: 7]    = 7'h55;
        stage_wdata[oth*25 +: 25] = 25'h1FFFFFF;
        for (int i = 0; i < nwr; i++) begin
            stage_we[idx] = 1'b1;
            stage_cnt[idx*7 +: 7] = 7'(i);
            stage_wdata[idx*25 +: 25] = pat(idx, i);
            #1;
            if (i == 0 || i == nwr - 1) begin
                check("wr_en", 32'(wr_en), 32'd1);
                check("wr_addr", 32'(wr_addr), 32'(i));
                check("rd_addr", 32'(rd_addr), 32'((i + 1) % 64));
                check("wr_data", 32'(wr_data), 32'(pat(idx, i)));
                check("rd_bank", 32'(rd_bank), 32'(exp_bank));
                check("wr_bank", 32'(wr_bank), 32'(1 - exp_bank));
            end
            @(negedge clk);
        end
        if (finish_stage) begin
            stage_we[idx]   = 1'b0;
            stage_done[idx] = 1'b1;
            #1;
            check("wr_en_unsel_ignored", 32'(wr_en), 32'd0);
            @(negedge clk);
            clear_stage_inputs();
        end
    endtask

    task automatic finish_check(input int exp_err, input int exp_done_seen);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_finish", 32'(busy), 32'd1);
        check("result_bank", 32'(result_bank), 32'd0);
        check("err_end", 32'(err), 32'(exp_err));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("done_count", 32'(done_seen), 32'(exp_done_seen));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_round"}, 32'(round), 32'd0);
        check({tag, "_stage_sel"}, 32'(stage_sel), 32'd0);
        check({tag, "_stage_start"}, 32'(stage_start), 32'd0);
        check({tag, "_rd_bank"}, 32'(rd_bank), 32'd0);
        check({tag, "_wr_bank"}, 32'(wr_bank), 32'd1);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_result_bank"}, 32'(result_bank), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        start_t = 1'b0;
        clear_stage_inputs();
        #1 rst = 1'b0;
        #1;
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Timeout: the second instance never sees stage_done.
        start_t = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        check("to_launch", 32'(stage_start_t), 32'd1);
        @(negedge clk);
        repeat (15) @(negedge clk);
        check("to_busy_before", 32'(busy_t), 32'd1);
        check("to_err_before", 32'(err_t), 32'd0);
        @(negedge clk);
        check("to_busy_after", 32'(busy_t), 32'd0);
        check("to_err_after", 32'(err_t), 32'd1);
        repeat (3) @(negedge clk);
        check("to_no_done", 32'(done_seen_t), 32'd0);

        // Nominal run: order 01,10,01,10, banks alternate, one done.
        start = 1'b1;
        run_stage(0, 64, 0, 0, 0, 1'b1);
        run_stage(1, 64, 0, 1, 0, 1'b1);
        run_stage(0, 64, 1, 0, 0, 1'b1);
        run_stage(1, 64, 1, 1, 0, 1'b1);
        finish_check(0, 1);

        // Short write in the second stage: err raised at SWAP, run still completes.
        start = 1'b1;
        run_stage(0, 64, 0, 0, 0, 1'b1);
        run_stage(1, 63, 0, 1, 0, 1'b1);
        run_stage(0, 64, 1, 0, 1, 1'b1);
        run_stage(1, 64, 1, 1, 1, 1'b1);
        finish_check(1, 2);

        // Asynchronous reset in WAIT of round 1 stage 1 with err set.
        start = 1'b1;
        run_stage(0, 63, 0, 0, 0, 1'b1);
        run_stage(1, 64, 0, 1, 1, 1'b1);
        run_stage(0, 64, 1, 0, 1, 1'b1);
        run_stage(1, 3, 1, 1, 1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        clear_stage_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_no_done", 32'(done_seen), 32'd2);
        check("midreset_idle", 32'(busy), 32'd0);

        // Abort in WAIT of round 1, start while busy ignored, then restart.
        start = 1'b1;
        run_stage(0, 63, 0, 0, 0, 1'b1);
        run_stage(1, 64, 0, 1, 1, 1'b1);
        run_stage(0, 4, 1, 0, 1, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_busy", 32'(busy), 32'd1);
        check("round_start_busy", 32'(round), 32'd1);
        check("sel_start_busy", 32'(stage_sel), 32'd0);
        check("no_relaunch", 32'(stage_start), 32'd0);
        abort = 1'b1;
        stage_done[0] = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        clear_stage_inputs();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_err_kept", 32'(err), 32'd1);
        check("abort_no_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_done_count", 32'(done_seen), 32'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_round", 32'(round), 32'd0);
        check("restart_err_clr", 32'(err), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_launch", 32'(stage_start), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/matrix_encoder_sched.md
MATRIX_ENCODER_SCHED -- requirements
Module: matrix_encoder_sched

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, number of stage functions run in order per round.
REQ-002 SHALL have parameter NUM_ROUNDS, default 24, number of rounds per run.
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum cycles a stage may run before abort.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, run request.
REQ-007 SHALL have port abort, input, 1, synchronous cancel.
REQ-008 SHALL have port busy, output, 1, run in progress.
REQ-009 SHALL have port done, output, 1, one-cycle end-of-run pulse.
REQ-010 SHALL have port err, output, 1, sticky error, cleared on accepted start.
REQ-011 SHALL have port round, output, 5, current round index.
REQ-012 SHALL have port stage_sel, output, 3, current stage index.
REQ-013 SHALL have port stage_start, output, NUM_STAGES, one-hot start pulse.
REQ-014 SHALL have port stage_done, input, NUM_STAGES, per-stage done.
REQ-015 SHALL have port stage_cnt, input, 7*NUM_STAGES, flat per-stage 7-bit line counters; stage k at [7k+6:7k].
REQ-016 SHALL have port stage_we, input, NUM_STAGES, per-stage write enables.
REQ-017 SHALL have port stage_wdata, input, 25*NUM_STAGES, flat per-stage 25-bit write data.
REQ-018 SHALL have port rd_bank, output, 1, source bank select.
REQ-019 SHALL have port rd_addr, output, 6, source line address.
REQ-020 SHALL have port wr_en, output, 1, destination write strobe.
REQ-021 SHALL have port wr_bank, output, 1, destination bank select, always the inverse of rd_bank.
REQ-022 SHALL have port wr_addr, output, 6, destination line address.
REQ-023 SHALL have port wr_data, output, 25, destination line data.
REQ-024 SHALL have port result_bank, output, 1, bank holding the final state after done.

Function
REQ-025 SHALL implement the FSM states IDLE, LAUNCH, WAIT, SWAP, FINISH.
REQ-026 SHALL, in IDLE with start=1, clear round, stage_sel, rd_bank and err, then enter LAUNCH.
REQ-027 SHALL, in LAUNCH, drive stage_start[stage_sel]=1 for exactly one cycle, clear write counter and timeout counter, then enter WAIT.
REQ-028 SHALL, in WAIT, combinationally route stage stage_sel: rd_addr = (stage_cnt[stage_sel][5:0]+1) mod 64, wr_en = stage_we[stage_sel], wr_data = stage_wdata[stage_sel], and hold wr_en at 0 for every other state.
REQ-029 SHALL drive wr_addr from a 7-bit write counter that starts at 0 per stage and increments on each wr_en cycle, using its low 6 bits.
REQ-030 SHALL ignore stage_done, stage_we and stage_cnt from unselected stages.
REQ-031 SHALL enter SWAP on stage_done[stage_sel]=1 in WAIT.
REQ-032 SHALL, in SWAP, set err if the write count is not 64 (any count other than exactly 64 writes is an error).
REQ-033 SHALL, in SWAP, toggle rd_bank.
REQ-034 SHALL, in SWAP, select the next step: stage_sel<NUM_STAGES-1 gives stage_sel+1 then LAUNCH; last stage and round<NUM_ROUNDS-1 gives stage_sel=0, round+1, then LAUNCH; last stage of last round gives FINISH.
REQ-035 SHALL, in FINISH, pulse done for one cycle, latch result_bank=rd_bank, then return to IDLE.
REQ-036 SHALL assert busy in every state except IDLE.
REQ-037 SHALL ignore start while busy.
REQ-038 SHALL, on abort=1 in any non-IDLE state, return to IDLE next cycle without a done pulse, with err unchanged; abort SHALL take priority over stage_done.
REQ-039 SHALL count WAIT cycles, and on the count reaching TIMEOUT set err and return to IDLE without done.
REQ-040 SHALL take the per-stage overhead as 2 cycles (LAUNCH + SWAP) plus the stage's own run time.

Reset
REQ-041 SHALL, while rst=0, asynchronously force IDLE with busy, done, err, round, stage_sel, stage_start, rd_bank and result_bank at 0, write and timeout counters at 0, and wr_bank at 1.
REQ-042 SHALL, on rst asserted mid-run, discard the run and issue no done.

Verification
REQ-043 SHALL cover a nominal run: NUM_STAGES=2, NUM_ROUNDS=2, model stages writing 64 lines each -> stage_start order 01,10,01,10; done once; result_bank=0; err=0.
REQ-044 SHALL cover a short write: a stage writes 63 lines then pulses done -> err=1 after SWAP; run completes with done.
REQ-045 SHALL cover address mapping: stage_cnt=63 in WAIT -> rd_addr=0; a write on the 64th we -> wr_addr=63.
REQ-046 SHALL cover a timeout: TIMEOUT=16 with a stage that never signals done -> err=1 and busy=0 at cycle 16 of WAIT, no done pulse.
REQ-047 SHALL cover abort and start interactions: abort during WAIT of round 1 -> IDLE with no done; start pulsed while busy -> no effect; a later start -> round=0, err cleared.
REQ-048 SHALL cover reset mid-run: rst=0 asserted asynchronously between clock edges in WAIT -> all outputs at reset values immediately.
